clk_std_switch: RTL
===================

# clk_std_switch

Glitch-free video-standard clock-switch sequencer for the top level. It runs from the raw oscillator clock and debounces the standard toggle switch. It also accepts register-driven standard requests and drives the select and per-source CE lines of an NUM_SRC-way global clock-buffer mux. The chip is held in reset across every switch, generalising the fixed two-way PAL/NTSC dot/colour mux to N standards with sequenced gating.

## Interface
- NUM_SRC, 3: number of clock sources / video standards (2..8)
- SEL_W, $clog2(NUM_SRC): select width
- DEFAULT_SEL, 0: selection after reset
- DEBOUNCE_CYCLES, 65536: stable cycles required on standard_sw
- GATE_CYCLES, 8: cycles all CEs held low before select change
- SETTLE_CYCLES, 16: cycles after select change before CE re-enable
- RESET_CYCLES, 1024: cycles chip_rst held after CE re-enable
- clk_col4x  in  1  free-running oscillator clock; only clock
- rst_n  in  1  asynchronous, active-low reset
- standard_sw  in  1  raw toggle switch, asynchronous
- req_sel  in  SEL_W  requested standard
- req_valid  in  1  request strobe
- req_ready  out  1  request accepted when valid&&ready
- sel_err  out  1  one-cycle pulse: accepted req_sel >= NUM_SRC
- clk_sel  out  SEL_W  mux select to clock buffers
- clk_ce  out  NUM_SRC  one-hot CE; all zero while gated
- chip_rst  out  1  active-high reset to vicii core
- busy  out  1  high whenever state != RUN

## Operation
- Reset values: clk_sel=DEFAULT_SEL, clk_ce=0, chip_rst=1, req_ready=0, sel_err=0, busy=1, state=SETTLE (power-up path), pending=0.
- FSM states: RUN, GATE_OFF, SWITCH, SETTLE, GATE_ON, RESET_HOLD.
- RUN: req_ready=1 unless a switch event is present or pending. A switch event has priority over a same-cycle request.
- Switch event in RUN: target=(clk_sel+1) mod NUM_SRC; go to GATE_OFF.
- Accepted request: req_sel==clk_sel is acknowledged as a no-op and stays in RUN. req_sel>=NUM_SRC pulses sel_err, is dropped, and stays in RUN. Otherwise target=req_sel; go to GATE_OFF.
- GATE_OFF: clk_ce=0, chip_rst=1, count GATE_CYCLES, then SWITCH.
- SWITCH: one cycle; clk_sel<=target; go to SETTLE.
- SETTLE: count SETTLE_CYCLES, then GATE_ON.
- GATE_ON: one cycle; clk_ce<=1<<clk_sel; go to RESET_HOLD.
- RESET_HOLD: count RESET_CYCLES, then chip_rst<=0 and go to RUN.
- Switch events during a sequence set pending. There is at most one pending event; further events are absorbed. Pending is serviced on the first RUN cycle.
- Requests outside RUN: req_ready=0; the requester holds req_valid.
- The power-up path (reset to SETTLE) does not count as a switch. The debouncer stable value tracks the synchronised input without generating events until the first RUN cycle.
- rst_n low at any point: all outputs return to reset values immediately (async). The sequence is aborted and pending is cleared.

## Timing
- All outputs are registered. Counters are $clog2(max)+1 bits and reload on state entry.
- Accepted request at edge E: clk_ce=0 and chip_rst=1 from E+1.
- clk_sel changes at E+1+GATE_CYCLES.
- clk_ce becomes one-hot at E+2+GATE_CYCLES+SETTLE_CYCLES.
- chip_rst falls RESET_CYCLES cycles after clk_ce rises.
- clk_sel never changes while any clk_ce bit is high.
- Debounce uses a 2-flop synchroniser. The counter clears whenever the synced input equals the stable value. The stable value flips, and a one-cycle event fires, when the input has differed for DEBOUNCE_CYCLES consecutive cycles. Latency is 2+DEBOUNCE_CYCLES cycles.

## Configuration
- CLK_SW_DEBOUNCE_EN defined: standard_sw is debounced as above.
- CLK_SW_DEBOUNCE_EN undefined: the debounce counter is removed. Any synchronised edge is an event, with latency 2 cycles. This configuration is for boards with hardware-debounced switches and for fast simulation.

## Structure
- Shared package clk_std_pkg: state encoding localparams and the counter-width function.
- Sub-module sw_debounce: synchroniser plus debounce counter. Outputs are the stable level and a one-cycle event. It contains the CLK_SW_DEBOUNCE_EN branch.

## Test plan
Bench parameters: NUM_SRC=3, DEFAULT_SEL=0, DEBOUNCE_CYCLES=16, GATE=4, SETTLE=8, RESET=32.
- Power-up: release rst_n -> clk_ce=3'b001 after 9 cycles; chip_rst falls 32 cycles later; req_ready rises with it.
- req_sel=2 accepted -> clk_ce=0 next cycle; clk_sel=2 after 5 cycles; clk_ce=3'b100 at 14 cycles; chip_rst low 32 cycles later; clk_sel stable while any CE is high.
- req_sel=0 while at 0 -> acknowledged, clk_ce unchanged. req_sel=3 -> sel_err for one cycle, no sequence.
- standard_sw glitch 10 cycles -> no event. Held for 16 cycles -> select 0->1. Repeated from 2 -> wraps to 0.
- Switch toggle during SETTLE -> second full sequence follows immediately after RUN. Switch event and req_valid in the same cycle -> switch wins, req_ready=0.
- rst_n low mid-SETTLE -> clk_ce=0, chip_rst=1, clk_sel=0 without a clock edge; full power-up path repeats after release.

Source files
------------

// File: rtl/clk_std_pkg.sv
// Shared state encodings and counter sizing for the video-standard clock switch.
// Latency: none (types, constants and helper functions only).
// Backpressure: none.
package clk_std_pkg;

    localparam logic [2:0] ST_RUN        = 3'd0;
    localparam logic [2:0] ST_GATE_OFF   = 3'd1;
    localparam logic [2:0] ST_SWITCH     = 3'd2;
    localparam logic [2:0] ST_SETTLE     = 3'd3;
    localparam logic [2:0] ST_GATE_ON    = 3'd4;
    localparam logic [2:0] ST_RESET_HOLD = 3'd5;

    typedef enum logic [2:0] {
        S_RUN        = ST_RUN,
        S_GATE_OFF   = ST_GATE_OFF,
        S_SWITCH     = ST_SWITCH,
        S_SETTLE     = ST_SETTLE,
        S_GATE_ON    = ST_GATE_ON,
        S_RESET_HOLD = ST_RESET_HOLD
    } state_e;

    // Counter width able to hold max_val with one spare bit of headroom.
    function automatic int cnt_w(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/clk_std_switch_sw_debounce.sv
// Synchroniser plus debouncer for the standard toggle switch: stable level and one-cycle event.
// Latency: 2+DEBOUNCE_CYCLES cycles with CLK_SW_DEBOUNCE_EN defined, 2 cycles otherwise.
// Backpressure: none; events are single-cycle pulses suppressed while arm is low.
module sw_debounce
    import clk_std_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_in,
    input  logic arm,
    output logic stable,
    output logic evt,
    output logic evt_nxt
);

    logic sync1_q, sync1_d;
    logic stable_q, stable_d;
    logic evt_q, evt_d;
    logic flip;

`ifdef CLK_SW_DEBOUNCE_EN
    localparam int DB_W = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync2_q, sync2_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;

    // Count consecutive cycles the synced input disagrees with the stable level.
    always_comb begin
        sync2_d  = sync1_q;
        db_cnt_d = db_cnt_q;
        flip     = 1'b0;
        if (sync2_q == stable_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            flip     = 1'b1;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    // Second synchroniser stage and debounce counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync2_q  <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            sync2_q  <= sync2_d;
            db_cnt_q <= db_cnt_d;
        end
    end
`else
    // Threshold has no meaning without the counter.
    logic [31:0] unused_db_cycles;
    assign unused_db_cycles = 32'(DEBOUNCE_CYCLES);

    // The stable flop is the second synchroniser stage, so any synced edge flips it.
    always_comb flip = (sync1_q != stable_q);
`endif

    // Stable level follows qualified flips; events only leave once armed.
    always_comb begin
        sync1_d  = sw_in;
        stable_d = stable_q ^ flip;
        evt_d    = flip & arm;
    end

    // First synchroniser stage, stable level and event pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            stable_q <= 1'b0;
            evt_q    <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            stable_q <= stable_d;
            evt_q    <= evt_d;
        end
    end

    assign stable  = stable_q;
    assign evt     = evt_q;
    assign evt_nxt = evt_d;

endmodule

// File: rtl/clk_std_switch.sv
// Glitch-free N-way video-standard clock switch sequencer; CLK_SW_DEBOUNCE_EN enables switch debouncing.
// Latency: accepted request gates CEs next cycle, new CE one-hot GATE+SETTLE+2 cycles after acceptance.
// Backpressure: req_ready low outside RUN or while a switch event is present/pending; requester holds req_valid.
module clk_std_switch
    import clk_std_pkg::*;
#(
    parameter int NUM_SRC         = 3,
    parameter int SEL_W           = $clog2(NUM_SRC),
    parameter int DEFAULT_SEL     = 0,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int GATE_CYCLES     = 8,
    parameter int SETTLE_CYCLES   = 16,
    parameter int RESET_CYCLES    = 1024
) (
    input  logic               clk_col4x,
    input  logic               rst_n,
    input  logic               standard_sw,
    input  logic [SEL_W-1:0]   req_sel,
    input  logic               req_valid,
    output logic               req_ready,
    output logic               sel_err,
    output logic [SEL_W-1:0]   clk_sel,
    output logic [NUM_SRC-1:0] clk_ce,
    output logic               chip_rst,
    output logic               busy
);

    localparam int CNT_W = cnt_w(max3(GATE_CYCLES, SETTLE_CYCLES, RESET_CYCLES));
    localparam logic [CNT_W-1:0]   GATE_LD   = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   RESET_LD  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [SEL_W-1:0]   SEL_MAX   = SEL_W'(NUM_SRC - 1);
    localparam logic [SEL_W-1:0]   DEF_SEL   = SEL_W'(DEFAULT_SEL);
    localparam logic [NUM_SRC-1:0] CE_ONE    = NUM_SRC'(1);
    localparam logic [SEL_W:0]     SEL_LIMIT = (SEL_W+1)'(NUM_SRC);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   target_q, target_d;
    logic               pending_q, pending_d;
    logic               armed_q, armed_d;
    logic [SEL_W-1:0]   clk_sel_q, clk_sel_d;
    logic [NUM_SRC-1:0] clk_ce_q, clk_ce_d;
    logic               chip_rst_q, chip_rst_d;
    logic               req_ready_q, req_ready_d;
    logic               sel_err_q, sel_err_d;
    logic               busy_q, busy_d;

    logic               sw_evt, sw_evt_nxt, sw_stable_unused, sw_arm;
    logic [SEL_W-1:0]   sw_target;
    logic               req_bad;
    logic               start_seq;

    // Events are held off until the sequencer has reached RUN once after reset.
    assign sw_arm = armed_q | (state_q == S_RUN);

    sw_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_debounce (
        .clk     (clk_col4x),
        .rst_n   (rst_n),
        .sw_in   (standard_sw),
        .arm     (sw_arm),
        .stable  (sw_stable_unused),
        .evt     (sw_evt),
        .evt_nxt (sw_evt_nxt)
    );

    assign sw_target = (clk_sel_q == SEL_MAX) ? '0 : clk_sel_q + SEL_W'(1);
    assign req_bad   = ({1'b0, req_sel} >= SEL_LIMIT);

    // Next-state and registered-output computation for the switch sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        target_d   = target_q;
        pending_d  = pending_q;
        armed_d    = armed_q;
        clk_sel_d  = clk_sel_q;
        clk_ce_d   = clk_ce_q;
        chip_rst_d = chip_rst_q;
        sel_err_d  = 1'b0;
        start_seq  = 1'b0;

        case (state_q)
            S_RUN: begin
                armed_d = 1'b1;
                if (sw_evt || pending_q) begin
                    // Switch wins over a same-cycle request; extra events collapse into one.
                    target_d  = sw_target;
                    pending_d = 1'b0;
                    start_seq = 1'b1;
                end else if (req_valid && req_ready_q) begin
                    if (req_bad) begin
                        sel_err_d = 1'b1;
                    end else if (req_sel != clk_sel_q) begin
                        target_d  = req_sel;
                        start_seq = 1'b1;
                    end
                end
            end
            S_GATE_OFF: begin
                if (cnt_q == '0) begin
                    state_d = S_SWITCH;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_SWITCH: begin
                clk_sel_d = target_q;
                state_d   = S_SETTLE;
                cnt_d     = SETTLE_LD;
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_GATE_ON;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_GATE_ON: begin
                clk_ce_d = CE_ONE << clk_sel_q;
                state_d  = S_RESET_HOLD;
                cnt_d    = RESET_LD;
            end
            S_RESET_HOLD: begin
                if (cnt_q == '0) begin
                    chip_rst_d = 1'b0;
                    state_d    = S_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                clk_ce_d   = '0;
                chip_rst_d = 1'b1;
                state_d    = S_SETTLE;
                cnt_d      = SETTLE_LD;
            end
        endcase

        if (start_seq) begin
            clk_ce_d   = '0;
            chip_rst_d = 1'b1;
            state_d    = S_GATE_OFF;
            cnt_d      = GATE_LD;
        end

        if ((state_q != S_RUN) && sw_evt) begin
            pending_d = 1'b1;
        end

        // Look one cycle ahead so an arriving switch event already drops ready.
        req_ready_d = (state_d == S_RUN) && !pending_d && !sw_evt_nxt;
        busy_d      = (state_d != S_RUN);
    end

    // Sequencer state and registered outputs; reset enters the power-up settle path.
    always_ff @(posedge clk_col4x or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_SETTLE;
            cnt_q       <= SETTLE_LD;
            target_q    <= DEF_SEL;
            pending_q   <= 1'b0;
            armed_q     <= 1'b0;
            clk_sel_q   <= DEF_SEL;
            clk_ce_q    <= '0;
            chip_rst_q  <= 1'b1;
            req_ready_q <= 1'b0;
            sel_err_q   <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            target_q    <= target_d;
            pending_q   <= pending_d;
            armed_q     <= armed_d;
            clk_sel_q   <= clk_sel_d;
            clk_ce_q    <= clk_ce_d;
            chip_rst_q  <= chip_rst_d;
            req_ready_q <= req_ready_d;
            sel_err_q   <= sel_err_d;
            busy_q      <= busy_d;
        end
    end

    assign clk_sel   = clk_sel_q;
    assign clk_ce    = clk_ce_q;
    assign chip_rst  = chip_rst_q;
    assign req_ready = req_ready_q;
    assign sel_err   = sel_err_q;
    assign busy      = busy_q;

endmodule
